// File: rtl/voice_mixer.sv
// Per-sample voice mixer: snapshots the voice bank on each synchronized lrck rise,
// sums the voices serially, applies a Q1.7 master gain, saturates, and holds the result.
module voice_mixer #(
    parameter int NUM_VOICES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CLIP_HOLD   = 25000000
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       lrck,
    input  logic [NUM_VOICES*16-1:0]   voice_in,
    input  logic [7:0]                 gain,
    input  logic                       mute,
    output logic [15:0]                out_l,
    output logic [15:0]                out_r,
    output logic                       sample_valid,
    output logic                       clip,
    output logic                       overrun,
    output logic [1:0]                 fsm_state
);

    localparam int AW = 16 + $clog2(NUM_VOICES);
    localparam int PW = AW + 9;
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int CW = $clog2(CLIP_HOLD + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ACC  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    logic [SYNC_STAGES-1:0] lrck_sync;
    logic                   lrck_q;
    logic                   tick;

    logic [1:0]             state;
    logic signed [15:0]     voice_q [NUM_VOICES];
    logic [7:0]             gain_q;
    logic                   mute_q;
    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   acc;
    logic signed [PW-1:0]   prod;
    logic                   clip_evt;
    logic [CW-1:0]          hold_cnt;

    logic signed [15:0]     voice_sel;
    logic signed [AW-1:0]   voice_ext;
    logic signed [PW-1:0]   acc_ext;
    logic signed [PW-1:0]   gain_ext;
    logic signed [PW-1:0]   mul;
    logic signed [PW-1:0]   scaled;
    logic                   in_range;
    logic                   sat_hit;
    logic [15:0]            out_val;

    assign tick      = lrck_sync[SYNC_STAGES-1] & ~lrck_q;
    assign fsm_state = state;
    assign clip      = (hold_cnt != '0) | clip_evt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            lrck_sync <= '0;
            lrck_q    <= 1'b0;
        end else begin
            lrck_sync <= {lrck_sync[SYNC_STAGES-2:0], lrck};
            lrck_q    <= lrck_sync[SYNC_STAGES-1];
        end
    end

    // Gain is unsigned, so a zero sign bit is prepended before the signed multiply.
    always_comb begin
        voice_sel = voice_q[idx];
        voice_ext = AW'(voice_sel);
        acc_ext   = PW'(acc);
        gain_ext  = PW'($signed({1'b0, gain_q}));
        mul       = acc_ext * gain_ext;
        scaled    = prod >>> 7;
        in_range  = (&scaled[PW-1:15]) | ~(|scaled[PW-1:15]);
        sat_hit   = ~in_range & ~mute_q;
        out_val   = 16'h0000;
        if (!mute_q) begin
            if (in_range)
                out_val = scaled[15:0];
            else
                out_val = scaled[PW-1] ? 16'h8000 : 16'h7FFF;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            for (int k = 0; k < NUM_VOICES; k++) voice_q[k] <= '0;
            gain_q       <= '0;
            mute_q       <= 1'b0;
            idx          <= '0;
            acc          <= '0;
            prod         <= '0;
            out_l        <= '0;
            out_r        <= '0;
            sample_valid <= 1'b0;
            clip_evt     <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            clip_evt     <= 1'b0;
            // Any tick outside IDLE (including the OUT cycle) is dropped.
            if (tick && state != S_IDLE)
                overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick) begin
                        for (int k = 0; k < NUM_VOICES; k++)
                            voice_q[k] <= voice_in[16*k +: 16];
                        gain_q <= gain;
                        mute_q <= mute;
                        acc    <= '0;
                        idx    <= '0;
                        state  <= S_ACC;
                    end
                end
                S_ACC: begin
                    acc <= acc + voice_ext;
                    idx <= idx + IW'(1);
                    if (idx == IW'(NUM_VOICES - 1))
                        state <= S_MUL;
                end
                S_MUL: begin
                    prod  <= mul;
                    state <= S_OUT;
                end
                S_OUT: begin
                    out_l        <= out_val;
                    out_r        <= out_val;
                    sample_valid <= 1'b1;
                    clip_evt     <= sat_hit;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // clip_evt lands with sample_valid; the counter then covers the remaining hold.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)
            hold_cnt <= '0;
        else if (clip_evt)
            hold_cnt <= CW'(CLIP_HOLD - 1);
        else if (hold_cnt != '0)
            hold_cnt <= hold_cnt - CW'(1);
    end

endmodule
